boot_loader: RTL and testbench



---
 rtl/boot_loader_pkg.sv | 24 ++
 rtl/boot_loader.sv | 124 ++++++++++++
 tb/tb_boot_loader.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/boot_loader_pkg.sv
// Shared definitions for the serial program loader: state encoding,
// stream framing constants and the running checksum step.
package boot_loader_pkg;

    typedef enum logic [2:0] {
        S_LEN_HI,
        S_LEN_LO,
        S_DAT_HI,
        S_DAT_LO,
        S_WRITE,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

    localparam int unsigned LEN_BYTES = 2;
    localparam logic        HI_FIRST  = 1'b1;

    // One step of the XOR checksum over the data bytes.
    function automatic logic [7:0] csum_step(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

endpackage

// File: rtl/boot_loader.sv
// Receives length header, program words and XOR checksum from a byte stream,
// writes the words to memory and releases the core once the image verifies.
module boot_loader
    import boot_loader_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR = 16'h0000,
    parameter int unsigned MAX_WORDS = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [15:0] adr,
    output logic [15:0] writedata,
    output logic        memwrite,
    output logic        core_reset,
    output logic        done,
    output logic        error,
    output logic [15:0] words_loaded
);

    state_t      state_q;
    logic [15:0] len_q;
    logic [15:0] idx_q;
    logic [7:0]  csum_q;
    logic [15:0] adr_q;
    logic [15:0] wdata_q;
    logic        memwrite_q;
    logic        core_reset_q;
    logic        done_q;
    logic        error_q;
    logic [15:0] words_q;

    logic [15:0] len_d;
    logic [15:0] idx_d;
    logic        accept;

    always_comb begin
        rx_ready = 1'b0;
        if (!reset) begin
            unique case (state_q)
                S_LEN_HI, S_LEN_LO, S_DAT_HI, S_DAT_LO, S_CSUM: rx_ready = 1'b1;
                default:                                        rx_ready = 1'b0;
            endcase
        end
        accept = rx_valid && rx_ready;
        len_d  = {len_q[15:8], rx_data};
        idx_d  = idx_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_LEN_HI;
            len_q        <= '0;
            idx_q        <= '0;
            csum_q       <= '0;
            adr_q        <= BASE_ADDR;
            wdata_q      <= '0;
            memwrite_q   <= 1'b0;
            core_reset_q <= 1'b1;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            words_q      <= '0;
        end else begin
            memwrite_q <= 1'b0;
            unique case (state_q)
                S_LEN_HI: if (accept) begin
                    len_q[15:8] <= rx_data;
                    state_q     <= S_LEN_LO;
                end
                S_LEN_LO: if (accept) begin
                    len_q <= len_d;
                    if (32'(len_d) > MAX_WORDS) begin
                        state_q <= S_ERR;
                        error_q <= 1'b1;
                    end else if (len_d == 16'd0) begin
                        state_q <= S_CSUM;
                    end else begin
                        state_q <= S_DAT_HI;
                    end
                end
                S_DAT_HI: if (accept) begin
                    wdata_q[15:8] <= rx_data;
                    csum_q        <= csum_step(csum_q, rx_data);
                    state_q       <= S_DAT_LO;
                end
                // Strobe and address are set here so they are registered in S_WRITE.
                S_DAT_LO: if (accept) begin
                    wdata_q[7:0] <= rx_data;
                    csum_q       <= csum_step(csum_q, rx_data);
                    adr_q        <= BASE_ADDR + idx_q;
                    memwrite_q   <= 1'b1;
                    state_q      <= S_WRITE;
                end
                S_WRITE: begin
                    idx_q   <= idx_d;
                    words_q <= words_q + 16'd1;
                    state_q <= (idx_d == len_q) ? S_CSUM : S_DAT_HI;
                end
                S_CSUM: if (accept) begin
                    if (rx_data == csum_q) begin
                        state_q      <= S_DONE;
                        done_q       <= 1'b1;
                        core_reset_q <= 1'b0;
                    end else begin
                        state_q <= S_ERR;
                        error_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign adr          = adr_q;
    assign writedata    = wdata_q;
    assign memwrite     = memwrite_q;
    assign core_reset   = core_reset_q;
    assign done         = done_q;
    assign error        = error_q;
    assign words_loaded = words_q;

endmodule

// File: tb/tb_boot_loader.sv
// Directed bench for boot_loader: nominal load, bad checksum, oversize header,
// empty image, stalled stream with address wrap, and reset mid-load.
module tb_boot_loader;
    import boot_loader_pkg::*;

    localparam logic [15:0] BASE = 16'hFFFE;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  rx_data = '0;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic [15:0] adr, writedata, words_loaded;
    logic        memwrite, core_reset, done, error;

    int total = 0;
    int bad = 0;
    int wr_cnt = 0;
    int gaps = 0;
    logic [15:0] mem [0:65535];

    always #5 clk = ~clk;

    boot_loader #(.BASE_ADDR(BASE), .MAX_WORDS(256)) dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .adr(adr), .writedata(writedata), .memwrite(memwrite),
        .core_reset(core_reset), .done(done), .error(error), .words_loaded(words_loaded)
    );

    // memwrite is registered, so sampling at posedge sees the cycle just ending.
    always @(posedge clk) begin
        if (memwrite === 1'b1) begin
            mem[adr] = writedata;
            wr_cnt   = wr_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        int n;
        for (int g = 0; g < gaps; g++) begin
            @(negedge clk);
            rx_valid = 1'b0;
            if ($urandom_range(0, 1) == 1) break;
        end
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        n = 0;
        while (rx_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("send_timeout", 32'(n), 32'd0);
        @(posedge clk);
        #1 rx_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset    = 1'b1;
        rx_valid = 1'b0;
        @(negedge clk);
        chk("rst_memwrite", 32'(memwrite), 32'd0);
        chk("rst_adr", 32'(adr), 32'(BASE));
        chk("rst_wdata", 32'(writedata), 32'd0);
        chk("rst_core_reset", 32'(core_reset), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        chk("rst_words", 32'(words_loaded), 32'd0);
        chk("rst_rx_ready", 32'(rx_ready), 32'd0);
        reset  = 1'b0;
        wr_cnt = 0;
        #1 chk("post_rst_ready", 32'(rx_ready), 32'd1);
    endtask

    logic [15:0] img [0:3];
    logic [7:0]  cs;

    initial begin
        // Nominal N=3 load; checksum 12^34^AB^CD^00^01 = 41
        do_reset();
        send(8'h00); send(8'h03);
        send(8'h12); send(8'h34);
        @(negedge clk);
        chk("t1_lat_memwrite", 32'(memwrite), 32'd1);
        chk("t1_lat_adr", 32'(adr), 32'(BASE));
        chk("t1_lat_wdata", 32'(writedata), 32'h1234);
        chk("t1_lat_ready", 32'(rx_ready), 32'd0);
        @(negedge clk);
        chk("t1_pulse_len", 32'(memwrite), 32'd0);
        send(8'hAB); send(8'hCD);
        send(8'h00); send(8'h01);
        send(8'h41);
        @(negedge clk);
        chk("t1_done", 32'(done), 32'd1);
        chk("t1_core_reset", 32'(core_reset), 32'd0);
        chk("t1_words", 32'(words_loaded), 32'd3);
        chk("t1_wr_cnt", 32'(wr_cnt), 32'd3);
        chk("t1_mem0", 32'(mem[16'hFFFE]), 32'h1234);
        chk("t1_mem1", 32'(mem[16'hFFFF]), 32'hABCD);
        chk("t1_mem2", 32'(mem[16'h0000]), 32'h0001);
        chk("t1_ready_done", 32'(rx_ready), 32'd0);

        // Bad checksum, then a held byte in S_ERR must be ignored
        do_reset();
        send(8'h00); send(8'h03);
        send(8'h12); send(8'h34); send(8'hAB); send(8'hCD); send(8'h00); send(8'h01);
        send(8'h00);
        @(negedge clk);
        chk("t2_error", 32'(error), 32'd1);
        chk("t2_done", 32'(done), 32'd0);
        chk("t2_core_reset", 32'(core_reset), 32'd1);
        chk("t2_ready", 32'(rx_ready), 32'd0);
        rx_data = 8'h55; rx_valid = 1'b1;
        repeat (5) @(negedge clk);
        rx_valid = 1'b0;
        chk("t2_wr_cnt", 32'(wr_cnt), 32'd3);
        chk("t2_words_frozen", 32'(words_loaded), 32'd3);

        // Oversize headers: 300 and the 257 boundary
        do_reset();
        send(8'h01); send(8'h2C);
        @(negedge clk);
        chk("t3_err300", 32'(error), 32'd1);
        repeat (4) @(negedge clk);
        chk("t3_no_write", 32'(wr_cnt), 32'd0);
        do_reset();
        send(8'h01); send(8'h01);
        @(negedge clk);
        chk("t3_err257", 32'(error), 32'd1);

        // Empty image
        do_reset();
        send(8'h00); send(8'h00); send(8'h00);
        @(negedge clk);
        chk("t4_done", 32'(done), 32'd1);
        chk("t4_no_write", 32'(wr_cnt), 32'd0);
        chk("t4_words", 32'(words_loaded), 32'd0);

        // Random stalls, address wrap past FFFF
        do_reset();
        gaps = 3;
        cs = '0;
        for (int i = 0; i < 4; i++) begin
            img[i] = 16'($urandom);
            cs = csum_step(cs, img[i][15:8]);
            cs = csum_step(cs, img[i][7:0]);
        end
        send(8'h00); send(8'h04);
        for (int i = 0; i < 4; i++) begin
            send(img[i][15:8]);
            send(img[i][7:0]);
        end
        send(cs);
        gaps = 0;
        @(negedge clk);
        chk("t5_done", 32'(done), 32'd1);
        chk("t5_wr_cnt", 32'(wr_cnt), 32'd4);
        for (int i = 0; i < 4; i++)
            chk($sformatf("t5_mem%0d", i), 32'(mem[BASE + 16'(i)]), 32'(img[i]));

        // Reset after second word, then a fresh N=1 image (BE^EF = 51)
        do_reset();
        send(8'h00); send(8'h03);
        send(8'h11); send(8'h22); send(8'h33); send(8'h44);
        for (int n = 0; n < 20 && wr_cnt < 2; n++) @(negedge clk);
        chk("t6_two_writes", 32'(wr_cnt), 32'd2);
        do_reset();
        send(8'h00); send(8'h01); send(8'hBE); send(8'hEF);
        @(negedge clk);
        chk("t6_adr", 32'(adr), 32'(BASE));
        chk("t6_memwrite", 32'(memwrite), 32'd1);
        send(8'h51);
        @(negedge clk);
        chk("t6_done", 32'(done), 32'd1);
        chk("t6_mem", 32'(mem[BASE]), 32'hBEEF);
        chk("t6_words", 32'(words_loaded), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
